// File: rtl/down_counter_reload_if.sv
// Control/status bundle between a timer user and down_counter_reload.
interface down_counter_reload_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             busy;
    logic             done;

    // Timer user: issues commands, observes count and status.
    modport master (
        output start, stop, en, auto_reload, load_val,
        input  out, tc, busy, done
    );

    // Counter: accepts commands, reports count and status.
    modport slave (
        input  start, stop, en, auto_reload, load_val,
        output out, tc, busy, done
    );
endinterface

// File: rtl/down_counter_reload.sv
// Loadable down counter with one-cycle terminal-count pulse and optional
// periodic auto-reload; usable as a timer or a divide-by-(N+1) enable.
module down_counter_reload #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    down_counter_reload_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] reload, reload_nx;
    logic             mode, mode_nx;
    logic             tc_q, tc_nx;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            reload <= '0;
            mode   <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            reload <= reload_nx;
            mode   <= mode_nx;
            tc_q   <= tc_nx;
        end
    end

    // Next state: stop beats start beats counting; tc is a single-edge pulse.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        reload_nx = reload;
        mode_nx   = mode;
        tc_nx     = 1'b0;
        if (bus.stop) begin
            state_nx = IDLE;
        end else if (bus.start) begin
            cnt_nx    = bus.load_val;
            reload_nx = bus.load_val;
            mode_nx   = bus.auto_reload;
            state_nx  = RUN;
        end else if (state == RUN && bus.en) begin
            if (cnt != '0) begin
                cnt_nx = cnt - WIDTH'(1);
            end else begin
                tc_nx = 1'b1;
                if (mode) begin
                    cnt_nx = reload;
                end else begin
                    state_nx = DONE;
                end
            end
        end
    end

    // Status decode from registered state only.
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.out = cnt;
    assign bus.tc  = tc_q;

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed test of down_counter_reload: reset, one-shot, periodic, gated
// enable, restart/stop, latched mode and zero load.
module tb_down_counter_reload;
    localparam int unsigned WIDTH = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    down_counter_reload_if #(.WIDTH(WIDTH)) bus ();

    down_counter_reload #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.en          = 1'b0;
        bus.auto_reload = 1'b0;
        bus.load_val    = '0;
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.load_val = 4'd5; bus.en = 1'b0;
        step();
        bus.start = 1'b0;
        n_checks++;
        if (bus.out !== 4'd5 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre: out=%0d busy=%0b expected out=5 busy=1", bus.out, bus.busy);
        end
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.out !== 4'd0 || bus.tc !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: out=%0d tc=%0b busy=%0b done=%0b expected 0 0 0 0", bus.out, bus.tc, bus.busy, bus.done);
        end
        #1 reset = 1'b0;
        bus.en = 1'b1;
        step(); step();
        n_checks++;
        if (bus.out !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
            n_fail++; $display("FAIL reset_after: out=%0d busy=%0b done=%0b tc=%0b expected IDLE zeros", bus.out, bus.busy, bus.done, bus.tc);
        end
        idle_inputs();
    endtask

    task automatic test_one_shot();
        logic [3:0] exp_seq [4];
        int         tc_seen;
        exp_seq[0] = 4'd3; exp_seq[1] = 4'd2; exp_seq[2] = 4'd1; exp_seq[3] = 4'd0;
        bus.start = 1'b1; bus.load_val = 4'd3; bus.auto_reload = 1'b0; bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.start = 1'b0;
            n_checks++;
            if (bus.out !== exp_seq[i] || bus.tc !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL one_shot_cnt[%0d]: out=%0d tc=%0b busy=%0b expected out=%0d tc=0 busy=1", i, bus.out, bus.tc, bus.busy, exp_seq[i]);
            end
        end
        step();
        n_checks++;
        if (bus.tc !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out !== 4'd0) begin
            n_fail++; $display("FAIL one_shot_tc: tc=%0b done=%0b busy=%0b out=%0d expected 1 1 0 0", bus.tc, bus.done, bus.busy, bus.out);
        end
        tc_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.tc === 1'b1) tc_seen++;
            n_checks++;
            if (bus.done !== 1'b1 || bus.out !== 4'd0) begin
                n_fail++; $display("FAIL one_shot_hold[%0d]: done=%0b out=%0d expected done=1 out=0", i, bus.done, bus.out);
            end
        end
        n_checks++;
        if (tc_seen !== 0) begin
            n_fail++; $display("FAIL one_shot_extra_tc: got %0d pulses expected 0", tc_seen);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL done_stop: done=%0b busy=%0b expected 0 0", bus.done, bus.busy);
        end
        idle_inputs();
    endtask

    task automatic test_periodic();
        logic [3:0] exp;
        logic       exp_tc;
        logic       prev_tc;
        int         pulses;
        bus.start = 1'b1; bus.load_val = 4'd2; bus.auto_reload = 1'b1; bus.en = 1'b1;
        step();
        bus.start = 1'b0;
        exp = 4'd2; pulses = 0; prev_tc = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            exp_tc = 1'b0;
            if (exp == 4'd0) begin exp = 4'd2; exp_tc = 1'b1; end
            else exp = exp - 4'd1;
            n_checks++;
            if (bus.out !== exp || bus.tc !== exp_tc) begin
                n_fail++; $display("FAIL periodic[%0d]: out=%0d tc=%0b expected out=%0d tc=%0b", k, bus.out, bus.tc, exp, exp_tc);
            end
            if (bus.tc === 1'b1) begin
                pulses++;
                n_checks++;
                if (prev_tc === 1'b1) begin
                    n_fail++; $display("FAIL periodic_width[%0d]: tc high two cycles expected one", k);
                end
            end
            prev_tc = bus.tc;
        end
        n_checks++;
        if (pulses !== 4) begin
            n_fail++; $display("FAIL periodic_pulses: got %0d expected 4", pulses);
        end
        bus.stop = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_en_toggle();
        logic [3:0] exp;
        logic       exp_tc;
        int         last_tc;
        int         spacing;
        bus.start = 1'b1; bus.load_val = 4'd15; bus.auto_reload = 1'b1; bus.en = 1'b1;
        step();
        bus.start = 1'b0;
        exp = 4'd15; last_tc = -1; spacing = 0;
        for (int k = 0; k < 70; k++) begin
            bus.en = (k % 2 == 0);
            step();
            exp_tc = 1'b0;
            if (k % 2 == 0) begin
                if (exp == 4'd0) begin exp = 4'd15; exp_tc = 1'b1; end
                else exp = exp - 4'd1;
            end
            n_checks++;
            if (bus.out !== exp || bus.tc !== exp_tc) begin
                n_fail++; $display("FAIL en_toggle[%0d]: out=%0d tc=%0b expected out=%0d tc=%0b", k, bus.out, bus.tc, exp, exp_tc);
            end
            if (bus.tc === 1'b1) begin
                if (last_tc >= 0) spacing = k - last_tc;
                last_tc = k;
            end
        end
        n_checks++;
        if (spacing !== 32) begin
            n_fail++; $display("FAIL en_toggle_spacing: got %0d expected 32", spacing);
        end
        bus.stop = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_restart();
        bus.start = 1'b1; bus.load_val = 4'd3; bus.auto_reload = 1'b0; bus.en = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step();
        n_checks++;
        if (bus.out !== 4'd1) begin
            n_fail++; $display("FAIL restart_pre: out=%0d expected 1", bus.out);
        end
        bus.start = 1'b1; bus.load_val = 4'd7;
        step();
        bus.start = 1'b0;
        n_checks++;
        if (bus.out !== 4'd7 || bus.tc !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL restart: out=%0d tc=%0b busy=%0b expected 7 0 1", bus.out, bus.tc, bus.busy);
        end
        step();
        n_checks++;
        if (bus.out !== 4'd6 || bus.tc !== 1'b0) begin
            n_fail++; $display("FAIL restart_cnt: out=%0d tc=%0b expected 6 0", bus.out, bus.tc);
        end
        bus.start = 1'b1; bus.stop = 1'b1; bus.load_val = 4'd9;
        step();
        bus.start = 1'b0; bus.stop = 1'b0;
        n_checks++;
        if (bus.out !== 4'd6 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc !== 1'b0) begin
            n_fail++; $display("FAIL start_stop: out=%0d busy=%0b done=%0b tc=%0b expected 6 0 0 0", bus.out, bus.busy, bus.done, bus.tc);
        end
        step(); step();
        n_checks++;
        if (bus.out !== 4'd6 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: out=%0d busy=%0b expected 6 0", bus.out, bus.busy);
        end
        idle_inputs();
    endtask

    task automatic test_latch();
        bus.start = 1'b1; bus.load_val = 4'd1; bus.auto_reload = 1'b0; bus.en = 1'b1;
        step();
        bus.start = 1'b0; bus.load_val = 4'd5; bus.auto_reload = 1'b1;
        step();
        n_checks++;
        if (bus.out !== 4'd0) begin
            n_fail++; $display("FAIL latch_cnt: out=%0d expected 0", bus.out);
        end
        step();
        n_checks++;
        if (bus.tc !== 1'b1 || bus.done !== 1'b1 || bus.out !== 4'd0) begin
            n_fail++; $display("FAIL latch_mode: tc=%0b done=%0b out=%0d expected 1 1 0", bus.tc, bus.done, bus.out);
        end
        bus.stop = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_zero_load();
        bus.start = 1'b1; bus.load_val = 4'd0; bus.auto_reload = 1'b0; bus.en = 1'b1;
        step();
        bus.start = 1'b0;
        n_checks++;
        if (bus.out !== 4'd0 || bus.tc !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL zero_one_shot_start: out=%0d tc=%0b busy=%0b expected 0 0 1", bus.out, bus.tc, bus.busy);
        end
        step();
        n_checks++;
        if (bus.tc !== 1'b1 || bus.done !== 1'b1) begin
            n_fail++; $display("FAIL zero_one_shot_tc: tc=%0b done=%0b expected 1 1", bus.tc, bus.done);
        end
        step();
        n_checks++;
        if (bus.tc !== 1'b0 || bus.done !== 1'b1) begin
            n_fail++; $display("FAIL zero_one_shot_after: tc=%0b done=%0b expected 0 1", bus.tc, bus.done);
        end
        bus.start = 1'b1; bus.auto_reload = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (bus.tc !== 1'b1 || bus.out !== 4'd0 || bus.busy !== 1'b1) begin
                n_fail++; $display("FAIL zero_periodic[%0d]: tc=%0b out=%0d busy=%0b expected 1 0 1", k, bus.tc, bus.out, bus.busy);
            end
        end
        bus.en = 1'b0;
        step();
        n_checks++;
        if (bus.tc !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL zero_periodic_en_off: tc=%0b busy=%0b expected 0 1", bus.tc, bus.busy);
        end
        bus.stop = 1'b1;
        step();
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        reset = 1'b1;
        step(); step();
        n_checks++;
        if (bus.out !== 4'd0 || bus.tc !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL por: out=%0d tc=%0b busy=%0b done=%0b expected zeros", bus.out, bus.tc, bus.busy, bus.done);
        end
        reset = 1'b0;
        step();
        test_reset();
        test_one_shot();
        test_periodic();
        test_en_toggle();
        test_restart();
        test_latch();
        test_zero_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
